// File: rtl/instr_issue_unit_pkg.sv
// Shared definitions for the instruction issue unit.
//   - Opcode constants for the instructions the unit issues or resolves.
//   - NOP_WORD: the value driven on the bus during bubbles.
//   - state_t: issue FSM states.
//   - is_issuable(): true for opcodes forwarded unchanged to the core.
package issue_pkg;

    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SW   = 6'h02;
    localparam logic [5:0] OP_LW   = 6'h04;
    localparam logic [5:0] OP_BZ   = 6'h08;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    function automatic logic is_issuable(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SW) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/instr_issue_unit_if.sv
// Bus between the issue unit, the program loader and the processor core.
//   start/stall        : execution control from the loader/bench
//   is0                : zero flag returned by the core
//   load_en/addr/data  : program-memory write port
//   Instruction/valid  : issued word to the core and its qualifier
//   pc/busy/done/issued: status of the issue unit
// The issue unit connects through the master modport; the loader/core
// side connects through the slave modport.
interface instr_issue_unit_if #(
    parameter int ADDR_W = 6
);

    logic              start;
    logic              stall;
    logic              is0;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic [31:0]       Instruction;
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
    logic [15:0]       issued;

    modport master (
        input  start, stall, is0, load_en, load_addr, load_data,
        output Instruction, valid, pc, busy, done, issued
    );

    modport slave (
        output start, stall, is0, load_en, load_addr, load_data,
        input  Instruction, valid, pc, busy, done, issued
    );

endinterface

// File: rtl/instr_issue_unit_rom.sv
// Program memory for the issue unit.
//   clk   : write clock
//   we    : write enable (already qualified by the FSM state)
//   waddr : write address
//   wdata : write data
//   raddr : combinational read address (the PC)
//   rdata : word at raddr
// Contents are deliberately not reset so a loaded program survives rst.
module instr_rom #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction issue unit: fetches from a loadable program memory and
// drives one registered instruction per cycle onto the core's bus.
// BZ, HALT and NOP/unknown words are resolved here and replaced by a bubble.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : instr_issue_unit_if master modport (control in, issue/status out)
module instr_issue_unit
    import issue_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    instr_issue_unit_if.master  bus
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_q, pc_nxt, pc_inc;
    logic [31:0]       instr_q, instr_nxt, word;
    logic              valid_q, valid_nxt;
    logic              zflag_q, zflag_nxt, z_eff;
    logic [15:0]       issued_q, issued_nxt;
    logic [5:0]        opcode;
    logic              mem_we;

    // Writes are only allowed while the program is not running.
    assign mem_we = bus.load_en && (state != RUN) && !rst;

    instr_rom #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (pc_q),
        .rdata (word)
    );

    assign opcode = word[31:26];
    assign pc_inc = pc_q + ADDR_W'(1);

    // The core answers is0 only for a real instruction on the bus; after a
    // bubble the last captured flag stands in for it.
    assign z_eff = valid_q ? bus.is0 : zflag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc_q     <= '0;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            zflag_q  <= 1'b0;
            issued_q <= '0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            instr_q  <= instr_nxt;
            valid_q  <= valid_nxt;
            zflag_q  <= zflag_nxt;
            issued_q <= issued_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        instr_nxt  = NOP_WORD;
        valid_nxt  = 1'b0;
        zflag_nxt  = valid_q ? bus.is0 : zflag_q;
        issued_nxt = issued_q;

        case (state)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (is_issuable(opcode)) begin
                        instr_nxt = word;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc_inc;
                        if (issued_q != 16'hFFFF) begin
                            issued_nxt = issued_q + 16'd1;
                        end
                    end else if (opcode == OP_BZ) begin
                        // Low ADDR_W bits of the offset equal those of its
                        // sign extension, so the sum wraps modulo DEPTH.
                        pc_nxt = z_eff ? (pc_inc + word[ADDR_W-1:0]) : pc_inc;
                    end else if (opcode == OP_HALT) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.Instruction = instr_q;
    assign bus.valid       = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == HALT);
    assign bus.issued      = issued_q;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed self-checking bench for instr_issue_unit. Expected issued words
// are queued when a program is started and popped as valid words appear.
module tb_instr_issue_unit;

    localparam logic [31:0] W_ADD  = 32'h0443_0800;
    localparam logic [31:0] W_SW   = 32'h0841_0000;
    localparam logic [31:0] W_LW   = 32'h1041_0000;
    localparam logic [31:0] W_HALT = 32'hFC00_0000;
    localparam logic [31:0] W_ADD2 = 32'h04A6_2000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] sb [$];

    instr_issue_unit_if #(.ADDR_W(6)) bus ();

    instr_issue_unit #(
        .DEPTH  (64),
        .ADDR_W (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one edge, then sample and score any issued word.
    task automatic tick();
        logic [31:0] exp_word;
        @(posedge clk);
        #1;
        if (bus.valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_issue", 32'(bus.valid), 32'd0);
            end else begin
                exp_word = sb.pop_front();
                checkOutput("issue_word", bus.Instruction, exp_word);
            end
        end
    endtask

    task automatic applyStimulus(input logic s_start, input logic s_stall,
                                 input logic s_is0);
        bus.start = s_start;
        bus.stall = s_stall;
        bus.is0   = s_is0;
        tick();
    endtask

    task automatic loadWord(input logic [5:0] addr, input logic [31:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        applyStimulus(1'b0, 1'b0, 1'b0);
        bus.load_en   = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            n++;
        end
        checkOutput("halt_reached", 32'(bus.done), 32'd1);
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.stall     = 1'b0;
        bus.is0       = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pc", 32'(bus.pc), 32'd0);
        checkOutput("rst_instr", bus.Instruction, 32'd0);
        checkOutput("rst_valid", 32'(bus.valid), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_issued", 32'(bus.issued), 32'd0);
        rst = 1'b0;

        // Basic program: add, sw, lw, halt
        loadWord(6'd0, W_ADD);
        loadWord(6'd1, W_SW);
        loadWord(6'd2, W_LW);
        loadWord(6'd3, W_HALT);
        sb.push_back(W_ADD); sb.push_back(W_SW); sb.push_back(W_LW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start_busy", 32'(bus.busy), 32'd1);
        checkOutput("start_valid", 32'(bus.valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("first_valid", 32'(bus.valid), 32'd1);
        checkOutput("first_pc", 32'(bus.pc), 32'd1);
        waitDone(10);
        checkOutput("t1_issued", 32'(bus.issued), 32'd3);
        checkOutput("t1_busy", 32'(bus.busy), 32'd0);
        checkOutput("t1_valid", 32'(bus.valid), 32'd0);

        // Two stall cycles mid-program
        sb.push_back(W_ADD); sb.push_back(W_SW); sb.push_back(W_LW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("stall_valid", 32'(bus.valid), 32'd0);
            checkOutput("stall_instr", bus.Instruction, 32'd0);
            checkOutput("stall_pc", 32'(bus.pc), 32'd1);
        end
        waitDone(10);
        checkOutput("t2_issued", 32'(bus.issued), 32'd6);

        // BZ +2 taken on live is0
        loadWord(6'd1, 32'h2000_0002);
        loadWord(6'd2, W_SW);
        loadWord(6'd3, W_LW);
        loadWord(6'd4, W_ADD2);
        loadWord(6'd5, W_HALT);
        sb.push_back(W_ADD); sb.push_back(W_ADD2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("bz_taken_pc", 32'(bus.pc), 32'd4);
        checkOutput("bz_taken_valid", 32'(bus.valid), 32'd0);
        waitDone(10);
        checkOutput("t3a_issued", 32'(bus.issued), 32'd8);

        // Same program, is0=0: falls through
        sb.push_back(W_ADD); sb.push_back(W_SW); sb.push_back(W_LW); sb.push_back(W_ADD2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("bz_nt_pc", 32'(bus.pc), 32'd2);
        waitDone(10);
        checkOutput("t3b_issued", 32'(bus.issued), 32'd12);

        // BZ at 63 with +0 wraps to 0 using the stored zflag
        loadWord(6'd1, 32'h2000_003D);
        loadWord(6'd2, W_HALT);
        loadWord(6'd63, 32'h2000_0000);
        sb.push_back(W_ADD); sb.push_back(W_ADD);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("bz61_pc", 32'(bus.pc), 32'd63);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("bz_wrap_pc", 32'(bus.pc), 32'd0);
        checkOutput("bz_wrap_valid", 32'(bus.valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("bz_second_nt_pc", 32'(bus.pc), 32'd2);
        waitDone(10);
        checkOutput("t4a_issued", 32'(bus.issued), 32'd14);

        // BZ -1 tight loop, then reset aborts the run
        loadWord(6'd1, 32'h2000_FFFF);
        sb.push_back(W_ADD);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("loop_pc", 32'(bus.pc), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("loop_pc_again", 32'(bus.pc), 32'd1);
        checkOutput("loop_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_pc", 32'(bus.pc), 32'd0);
        checkOutput("abort_valid", 32'(bus.valid), 32'd0);
        checkOutput("abort_instr", bus.Instruction, 32'd0);
        checkOutput("abort_issued", 32'(bus.issued), 32'd0);
        checkOutput("abort_sb", 32'(sb.size()), 32'd0);

        // Load during RUN is ignored
        loadWord(6'd1, W_SW);
        loadWord(6'd2, W_LW);
        loadWord(6'd3, W_HALT);
        sb.push_back(W_ADD); sb.push_back(W_SW); sb.push_back(W_LW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        bus.load_en   = 1'b1;
        bus.load_addr = 6'd2;
        bus.load_data = W_HALT;
        applyStimulus(1'b0, 1'b0, 1'b0);
        bus.load_en   = 1'b0;
        waitDone(10);
        checkOutput("t6a_issued", 32'(bus.issued), 32'd3);

        // Load in HALT, with the last write coinciding with start
        loadWord(6'd1, W_HALT);
        bus.load_en   = 1'b1;
        bus.load_addr = 6'd0;
        bus.load_data = W_LW;
        sb.push_back(W_LW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        bus.load_en   = 1'b0;
        checkOutput("ldstart_pc", 32'(bus.pc), 32'd0);
        checkOutput("ldstart_busy", 32'(bus.busy), 32'd1);
        waitDone(10);
        checkOutput("t6b_issued", 32'(bus.issued), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
